// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator job sequencer: register map
// word indices (byte offset >> 2), CTRL/STATUS bit positions, FSM encoding.
package cnn_accel_pkg;

    localparam logic [3:0] REG_CTRL        = 4'h0;
    localparam logic [3:0] REG_STATUS      = 4'h1;
    localparam logic [3:0] REG_SRC_BASE    = 4'h2;
    localparam logic [3:0] REG_DST_BASE    = 4'h3;
    localparam logic [3:0] REG_NUM_TILES   = 4'h4;
    localparam logic [3:0] REG_TILE_STRIDE = 4'h5;
    localparam logic [3:0] REG_TILES_DONE  = 4'h6;
    localparam logic [3:0] REG_CYCLES      = 4'h7;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_ABORTED = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/cnn_accel_ctrl_if.sv
// MMIO + tile-request bundle of the job sequencer. "slave" is the sequencer
// side, "master" is the MMIO host plus compute datapath side.
// Tile handshake: tile_req_valid rises with stable addresses and stays high
// with addresses unchanged until the cycle tile_req_ready is also high; that
// cycle is the transfer. tile_done pulses once per transferred tile and
// tile_err is meaningful only while tile_done is high.
interface cnn_accel_ctrl_if #(
    parameter int ADDR_W = 32
);
    import cnn_accel_pkg::*;

    logic              mmio_write_en;
    logic              mmio_read_en;
    logic [31:0]       mmio_addr;
    logic [31:0]       mmio_wdata;
    logic [31:0]       mmio_rdata;
    logic              tile_req_valid;
    logic              tile_req_ready;
    logic [ADDR_W-1:0] tile_src_addr;
    logic [ADDR_W-1:0] tile_dst_addr;
    logic              tile_done;
    logic              tile_err;
    logic              intr;
    state_e            dbg_state;

    modport slave (
        input  mmio_write_en, mmio_read_en, mmio_addr, mmio_wdata,
        input  tile_req_ready, tile_done, tile_err,
        output mmio_rdata, tile_req_valid, tile_src_addr, tile_dst_addr,
        output intr, dbg_state
    );

    modport master (
        output mmio_write_en, mmio_read_en, mmio_addr, mmio_wdata,
        output tile_req_ready, tile_done, tile_err,
        input  mmio_rdata, tile_req_valid, tile_src_addr, tile_dst_addr,
        input  intr, dbg_state
    );

endinterface

// File: rtl/cnn_accel_ctrl_regfile.sv
// Control/status register file: MMIO decode, W1C status, config registers,
// registered read mux and registered interrupt.
// Optional busy-cycle counter at 0x1C is built only with CNN_CTRL_PERF_EN.
module cnn_accel_ctrl_regfile
    import cnn_accel_pkg::*;
#(
    parameter int TILE_CNT_W = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en_i,
    input  logic                  read_en_i,
    input  logic [3:0]            reg_idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    input  logic                  busy_i,
    input  logic                  start_accept_i,
    input  logic                  set_done_i,
    input  logic                  set_err_i,
    input  logic                  set_aborted_i,
    input  logic [TILE_CNT_W-1:0] tiles_done_i,
    output logic                  start_o,
    output logic                  abort_o,
    output logic [ADDR_W-1:0]     src_base_o,
    output logic [ADDR_W-1:0]     dst_base_o,
    output logic [ADDR_W-1:0]     stride_o,
    output logic [TILE_CNT_W-1:0] num_tiles_o,
    output logic                  intr_o
);

    logic                  irq_en_q, irq_en_d;
    logic                  done_q, done_d, err_q, err_d, aborted_q, aborted_d;
    logic [ADDR_W-1:0]     src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [ADDR_W-1:0]     stride_q, stride_d;
    logic [TILE_CNT_W-1:0] num_tiles_q, num_tiles_d;
    logic [31:0]           rdata_q, rdata_d, rd_val;
    logic                  intr_q, intr_d;
    logic                  ctrl_wr, stat_wr, cfg_wr;

    assign ctrl_wr = write_en_i && (reg_idx_i == REG_CTRL);
    assign stat_wr = write_en_i && (reg_idx_i == REG_STATUS);
    // Job configuration is frozen while a job is running.
    assign cfg_wr  = write_en_i && !busy_i;

    // ABORT wins over START in the same write.
    assign start_o = ctrl_wr && wdata_i[CTRL_START] && !wdata_i[CTRL_ABORT];
    assign abort_o = ctrl_wr && wdata_i[CTRL_ABORT];

`ifdef CNN_CTRL_PERF_EN
    logic [31:0] cycles_q, cycles_d;

    // Busy-cycle counter: cleared by an accepted START, saturating.
    always_comb begin
        cycles_d = cycles_q;
        if (start_accept_i)
            cycles_d = '0;
        else if (busy_i && (cycles_q != 32'hFFFF_FFFF))
            cycles_d = cycles_q + 32'd1;
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept_i;
`endif

    // Next-state for config, status (hardware set beats W1C) and interrupt.
    always_comb begin
        irq_en_d    = irq_en_q;
        src_base_d  = src_base_q;
        dst_base_d  = dst_base_q;
        num_tiles_d = num_tiles_q;
        stride_d    = stride_q;
        if (ctrl_wr)
            irq_en_d = wdata_i[CTRL_IRQ_EN];
        if (cfg_wr && (reg_idx_i == REG_SRC_BASE))    src_base_d  = wdata_i[ADDR_W-1:0];
        if (cfg_wr && (reg_idx_i == REG_DST_BASE))    dst_base_d  = wdata_i[ADDR_W-1:0];
        if (cfg_wr && (reg_idx_i == REG_NUM_TILES))   num_tiles_d = wdata_i[TILE_CNT_W-1:0];
        if (cfg_wr && (reg_idx_i == REG_TILE_STRIDE)) stride_d    = wdata_i[ADDR_W-1:0];
        done_d    = (done_q    && !(stat_wr && wdata_i[STAT_DONE]))    || set_done_i;
        err_d     = (err_q     && !(stat_wr && wdata_i[STAT_ERR]))     || set_err_i;
        aborted_d = (aborted_q && !(stat_wr && wdata_i[STAT_ABORTED])) || set_aborted_i;
        intr_d    = irq_en_q && (done_q || err_q || aborted_q);
    end

    // Read mux; rdata only updates on a read strobe.
    always_comb begin
        rd_val = '0;
        case (reg_idx_i)
            REG_CTRL:        rd_val[CTRL_IRQ_EN] = irq_en_q;
            REG_STATUS:      rd_val[3:0] = {aborted_q, err_q, done_q, busy_i};
            REG_SRC_BASE:    rd_val[ADDR_W-1:0] = src_base_q;
            REG_DST_BASE:    rd_val[ADDR_W-1:0] = dst_base_q;
            REG_NUM_TILES:   rd_val[TILE_CNT_W-1:0] = num_tiles_q;
            REG_TILE_STRIDE: rd_val[ADDR_W-1:0] = stride_q;
            REG_TILES_DONE:  rd_val[TILE_CNT_W-1:0] = tiles_done_i;
`ifdef CNN_CTRL_PERF_EN
            REG_CYCLES:      rd_val = cycles_q;
`endif
            default:         rd_val = '0;
        endcase
        rdata_d = read_en_i ? rd_val : rdata_q;
    end

    // Register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            num_tiles_q <= '0;
            stride_q    <= '0;
            rdata_q     <= '0;
            intr_q      <= 1'b0;
        end else begin
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            aborted_q   <= aborted_d;
            src_base_q  <= src_base_d;
            dst_base_q  <= dst_base_d;
            num_tiles_q <= num_tiles_d;
            stride_q    <= stride_d;
            rdata_q     <= rdata_d;
            intr_q      <= intr_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign intr_o      = intr_q;
    assign src_base_o  = src_base_q;
    assign dst_base_o  = dst_base_q;
    assign stride_o    = stride_q;
    assign num_tiles_o = num_tiles_q;

endmodule

// File: rtl/cnn_accel_ctrl.sv
// CNN accelerator job sequencer: walks NUM_TILES tiles, one request at a
// time, advancing source/destination addresses by TILE_STRIDE.
// Optional CYCLES counter (0x1C) is enabled by defining CNN_CTRL_PERF_EN.
module cnn_accel_ctrl
    import cnn_accel_pkg::*;
#(
    parameter int TILE_CNT_W = 16,
    parameter int ADDR_W     = 32
) (
    input logic            clk,
    input logic            reset,
    cnn_accel_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     src_q, src_d, dst_q, dst_d;
    logic [TILE_CNT_W-1:0] tiles_done_q, tiles_done_d, tiles_done_inc;
    logic [ADDR_W-1:0]     src_base, dst_base, stride;
    logic [TILE_CNT_W-1:0] num_tiles;
    logic                  start, abort, busy, last_tile;
    logic                  req_valid, load, advance, start_accept;
    logic                  set_done, set_err, set_aborted;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{bus.mmio_addr[31:6], bus.mmio_addr[1:0]};

    assign busy           = (state_q != ST_IDLE);
    assign tiles_done_inc = tiles_done_q + TILE_CNT_W'(1);
    assign last_tile      = (tiles_done_inc == num_tiles);

    cnn_accel_ctrl_regfile #(
        .TILE_CNT_W(TILE_CNT_W),
        .ADDR_W    (ADDR_W)
    ) u_regfile (
        .clk           (clk),
        .reset         (reset),
        .write_en_i    (bus.mmio_write_en),
        .read_en_i     (bus.mmio_read_en),
        .reg_idx_i     (bus.mmio_addr[5:2]),
        .wdata_i       (bus.mmio_wdata),
        .rdata_o       (bus.mmio_rdata),
        .busy_i        (busy),
        .start_accept_i(start_accept),
        .set_done_i    (set_done),
        .set_err_i     (set_err),
        .set_aborted_i (set_aborted),
        .tiles_done_i  (tiles_done_q),
        .start_o       (start),
        .abort_o       (abort),
        .src_base_o    (src_base),
        .dst_base_o    (dst_base),
        .stride_o      (stride),
        .num_tiles_o   (num_tiles),
        .intr_o        (bus.intr)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state. An abort racing the handshake lets the tile go and drains it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && (num_tiles != '0)) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (bus.tile_req_ready) state_d = abort ? ST_DRAIN : ST_WAIT;
                else if (abort)         state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.tile_done)
                    state_d = (bus.tile_err || last_tile || abort) ? ST_IDLE : ST_ISSUE;
                else if (abort)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: if (bus.tile_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request valid, counter controls and status set pulses.
    always_comb begin
        req_valid    = 1'b0;
        load         = 1'b0;
        advance      = 1'b0;
        start_accept = 1'b0;
        set_done     = 1'b0;
        set_err      = 1'b0;
        set_aborted  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    load         = 1'b1;
                    set_done     = (num_tiles == '0);
                end
            end
            ST_ISSUE: begin
                req_valid   = 1'b1;
                set_aborted = abort && !bus.tile_req_ready;
            end
            ST_WAIT: begin
                if (bus.tile_done) begin
                    advance = 1'b1;
                    if (bus.tile_err)  set_err     = 1'b1;
                    else if (last_tile) set_done   = 1'b1;
                    else if (abort)     set_aborted = 1'b1;
                end
            end
            ST_DRAIN: set_aborted = bus.tile_done;
            default: ;
        endcase
    end

    // Working address / tile counter next state.
    always_comb begin
        src_d        = src_q;
        dst_d        = dst_q;
        tiles_done_d = tiles_done_q;
        if (load) begin
            src_d        = src_base;
            dst_d        = dst_base;
            tiles_done_d = '0;
        end else if (advance) begin
            src_d        = src_q + stride;
            dst_d        = dst_q + stride;
            tiles_done_d = tiles_done_inc;
        end
    end

    // Working address / tile counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q        <= '0;
            dst_q        <= '0;
            tiles_done_q <= '0;
        end else begin
            src_q        <= src_d;
            dst_q        <= dst_d;
            tiles_done_q <= tiles_done_d;
        end
    end

    assign bus.tile_req_valid = req_valid;
    assign bus.tile_src_addr  = src_q;
    assign bus.tile_dst_addr  = dst_q;
    assign bus.dbg_state      = state_q;

endmodule

// File: doc/cnn_accel_ctrl.md
Name: cnn_accel_ctrl

Overview:
MMIO-programmable job sequencer for the CNN accelerator. Sits between the TileLink MMIO slave interface of the accelerator top and the compute datapath. Holds the control/status registers and walks a job of NUM_TILES tiles, issuing one tile request at a time and waiting for completion. Raises a level interrupt to RocketChip on job completion or error.

Parameters:
- TILE_CNT_W, 16, width of the tile count and tiles-done counter.
- ADDR_W, 32, width of the tile source/destination addresses.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mmio_write_en  in  1  single-cycle write strobe.
- mmio_read_en  in  1  single-cycle read strobe.
- mmio_addr  in  32  byte address; decode on [5:2], ignore the rest.
- mmio_wdata  in  32  write data.
- mmio_rdata  out  32  registered read data.
- tile_req_valid  out  1  tile request valid.
- tile_req_ready  in  1  datapath accepts the request.
- tile_src_addr  out  ADDR_W  source address of the current tile.
- tile_dst_addr  out  ADDR_W  destination address of the current tile.
- tile_done  in  1  one-cycle pulse; the accepted tile has finished.
- tile_err  in  1  qualified by tile_done; the tile failed.
- intr  out  1  level interrupt.

Behaviour:
Register map (byte offset):
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 ABORT (write-1 pulse, reads 0); bit2 IRQ_EN (R/W).
- 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C); bit3 ABORTED (W1C).
- 0x08 SRC_BASE, 0x0C DST_BASE, 0x10 NUM_TILES (low TILE_CNT_W bits), 0x14 TILE_STRIDE: all R/W.
- 0x18 TILES_DONE: RO.
- Unmapped offsets read 0; writes to them are ignored.

Read and write rules:
- mmio_rdata is updated the cycle after mmio_read_en and holds its value otherwise.
- Writes to 0x08–0x14 while BUSY are ignored.

Reset:
- All registers 0, FSM in IDLE.
- mmio_rdata, tile_req_valid, tile_src_addr, tile_dst_addr and intr are 0.

FSM (IDLE, ISSUE, WAIT, DRAIN):
- IDLE: START loads the working addresses from SRC_BASE/DST_BASE, clears TILES_DONE and sets BUSY.
  - If NUM_TILES=0: set DONE next cycle and stay in IDLE; no request is issued.
  - Otherwise go to ISSUE.
- ISSUE: tile_req_valid=1 and addresses held stable until tile_req_ready; the handshake cycle moves to WAIT. valid must not drop before ready.
- WAIT: on tile_done, TILES_DONE increments and both addresses advance by TILE_STRIDE (modulo 2^ADDR_W).
  - If tile_err: set ERR, clear BUSY, go to IDLE.
  - Else if TILES_DONE+1 == NUM_TILES: set DONE, clear BUSY, go to IDLE.
  - Else go to ISSUE.
- ABORT in ISSUE before the handshake: drop valid next cycle, go to IDLE, set ABORTED, clear BUSY.
- ABORT in WAIT: go to DRAIN. DRAIN waits for tile_done, then goes to IDLE with ABORTED set.
- ABORT in IDLE has no effect.
- START while BUSY is ignored.
- START and ABORT in the same write: ABORT wins; START is ignored.

Status bits and interrupt:
- A W1C clear and a hardware set in the same cycle: set wins.
- intr is registered: intr <= IRQ_EN & (DONE | ERR | ABORTED).

Optional Feature:
- Macro CNN_CTRL_PERF_EN.
- Defined: register 0x1C CYCLES (RO, 32-bit) clears on an accepted START, counts every cycle BUSY=1, and saturates at 0xFFFFFFFF.
- Undefined: 0x1C reads 0 and no counter is synthesised.

Decomposition:
- Package cnn_accel_pkg: register offset localparams, CTRL/STATUS bit indices, FSM state encoding.
- One sub-module is natural: cnn_accel_ctrl_regfile (MMIO decode, registers, W1C logic, rdata mux). The FSM and address counters stay in cnn_accel_ctrl.

Test Plan:
- Reset, then read all offsets -> all read 0; intr=0; tile_req_valid=0.
- SRC_BASE=0x1000, DST_BASE=0x8000, STRIDE=0x100, NUM_TILES=3, IRQ_EN=1, START; ready held high, tile_done 4 cycles after each accept -> requests at (0x1000,0x8000), (0x1100,0x8100), (0x1200,0x8200); TILES_DONE=3; STATUS=0x2; intr=1. W1C 0x2 -> intr=0 the cycle after.
- NUM_TILES=0, START -> no tile_req_valid; DONE set within 1 cycle; BUSY never observed high on read.
- NUM_TILES=5, tile_err with the 2nd tile_done -> ERR=1, TILES_DONE=2, no 3rd request, intr=1.
- ABORT while in WAIT on tile 1 -> no new request; ABORTED is set only after tile_done; a later START runs normally. ABORT with ready low in ISSUE -> valid drops next cycle.
- Write SRC_BASE while BUSY -> value unchanged. Write 0x3 to CTRL -> abort semantics only. Assert reset mid-job -> outputs 0 immediately (asynchronous).
